packet_fifo_buffer: RTL and testbench
=====================================

Name: packet_fifo_buffer

Overview:
Parametrised packet buffer for the display-decoder NoC. It replaces a single always-loading packet register with a DEPTH-entry FIFO of NIBBLES-wide packets, using valid/ready handshakes on both sides. It sits between a packet source (router port or decoder front end) and a downstream consumer, and absorbs backpressure. It also reports occupancy, synchronous flush and a saturating stall counter for debug.

Parameters:
NIBBLES, 6, number of 4-bit fields per packet; packet width W = 4*NIBBLES (default 24)
DEPTH, 4, number of packet entries; power of two, minimum 2
STALL_W, 8, width of the saturating stall counter

Ports:
clock  input  1  rising-edge clock
clear_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; empties the FIFO
in_valid  input  1  source presents a packet
in_ready  output  1  buffer can accept a packet
in_packet  input  W  incoming packet
out_valid  output  1  buffer holds a packet for the consumer
out_ready  input  1  consumer accepts the head packet
out_packet  output  W  head packet (oldest entry)
count  output  $clog2(DEPTH+1)  number of entries held
full  output  1  count == DEPTH
empty  output  1  count == 0
stall_count  output  STALL_W  cycles with in_valid=1 and in_ready=0; saturating

Behaviour:
- Reset (clear_n low, asynchronous) forces the following, regardless of clock:
  - wr_ptr, rd_ptr and count go to 0; stall_count goes to 0.
  - empty=1, full=0, out_valid=0, in_ready=1.
  - Storage contents are don't-care. out_packet is 0 while empty (see below).
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated on the rising clock edge.
- in_ready = !full & !flush.
  - in_ready does not depend on out_ready; there is no combinational in->out path.
  - Therefore, when full, a simultaneous pop does not admit a push in the same cycle.
- out_valid = !empty.
- out_packet = mem[rd_ptr] when !empty, and all zeros when empty.
- Latency: a packet pushed on edge N is visible on out_packet/out_valid after edge N (first cycle after the push). Minimum latency through the buffer is 1 cycle.
- Ordering is strict FIFO. Packet bits are stored and returned unmodified; nibble k occupies bits [4k+3:4k].
- Pointers are log2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally. count is tracked separately.
- Count update per cycle:
  - push & !pop: +1
  - pop & !push: -1
  - push & pop: unchanged, both pointers advance (only possible when 0 < count < DEPTH)
- Empty and push: out_valid stays 0 that cycle, so no pop can occur; count becomes 1.
- Flush (synchronous, highest priority):
  - On the edge where flush=1, wr_ptr, rd_ptr and count go to 0.
  - Any push or pop in that cycle is ignored; in_ready is already 0 because of the flush term.
  - stall_count is not cleared by flush.
- stall_count increments on every edge with in_valid=1 & in_ready=0, including flush cycles. It saturates at 2^STALL_W-1 and never wraps.
- full and empty are derived combinationally from the registered count.
- Reset asserted mid-transfer discards all contents immediately. The first edge after clear_n rises behaves as from empty.
- Illegal parameter values (DEPTH not a power of two, or DEPTH<2) are rejected by an elaboration-time assertion.

Test Plan:
- Reset, then push 0x123456 with out_ready=0 -> next cycle: out_valid=1, out_packet=0x123456, count=1, empty=0.
- Push 0xA00001, 0xA00002, 0xA00003, 0xA00004 with out_ready=0 -> full=1, in_ready=0, count=4. Hold in_valid=1 for 3 more cycles -> stall_count=3 and contents unchanged. Then drain with out_ready=1 -> outputs appear in order 0xA00001..0xA00004, then empty=1 and out_packet=0.
- Streaming with in_valid=1 and out_ready=1 for 10 cycles, data 0x000000..0x000009 -> count stays 1 after the first edge, outputs arrive in order, and pointers wrap twice without loss.
- Full, then assert out_ready=1 and in_valid=1 in the same cycle -> pop occurs, no push, count=3. On the next cycle the push is accepted and count=4.
- Count=3, assert flush with in_valid=1 and out_ready=1 -> after the edge count=0, empty=1, no data accepted, stall_count +1.
- Drive clear_n low asynchronously mid-cycle with count=2 -> outputs go to reset values immediately, without waiting for a clock edge. Drive stall_count to saturation (255) -> it holds at 255.

Source files
------------

// File: rtl/packet_fifo_buffer.sv
// DEPTH-entry packet FIFO with valid/ready on both sides, occupancy flags,
// synchronous flush and a saturating stall counter for debug.
module packet_fifo_buffer #(
  parameter int unsigned NIBBLES = 6,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned STALL_W = 8
) (
  input  logic                         clock,
  input  logic                         clear_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4*NIBBLES-1:0]         in_packet,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*NIBBLES-1:0]         out_packet,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic [STALL_W-1:0]           stall_count
);

  localparam int unsigned W  = 4 * NIBBLES;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gen_bad_depth
    $error("packet_fifo_buffer: DEPTH must be a power of two and at least 2");
  end

  logic [W-1:0]       mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic               push, pop;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  // in_ready ignores out_ready so there is no combinational in->out path.
  assign in_ready    = !full && !flush;
  assign out_valid   = !empty;
  assign push        = in_valid && in_ready;
  assign pop         = out_valid && out_ready;
  assign count       = count_q;
  assign stall_count = stall_q;
  assign out_packet  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Stalls are counted during flush too; the counter survives flush.
  always_comb begin
    stall_d = stall_q;
    if (in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      stall_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      stall_q  <= stall_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= in_packet;
  end

endmodule

// File: tb/tb_packet_fifo_buffer.sv
// Self-checking bench for packet_fifo_buffer: directed scenarios plus a
// randomized run, all compared against a queue-based reference model.
module tb_packet_fifo_buffer;

  localparam int unsigned NIBBLES = 6;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned STALL_W = 8;
  localparam int unsigned W       = 4 * NIBBLES;
  localparam int unsigned CW      = $clog2(DEPTH + 1);
  localparam int          SMAX    = (1 << STALL_W) - 1;

  logic          clock = 1'b0;
  logic          clear_n, flush, in_valid, in_ready, out_valid, out_ready, full, empty;
  logic [W-1:0]  in_packet, out_packet;
  logic [CW-1:0] count;
  logic [STALL_W-1:0] stall_count;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] model_q[$];
  int           model_stall;

  packet_fifo_buffer #(.NIBBLES(NIBBLES), .DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
    .clock(clock), .clear_n(clear_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_packet(in_packet),
    .out_valid(out_valid), .out_ready(out_ready), .out_packet(out_packet),
    .count(count), .full(full), .empty(empty), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // Expected {out_valid, in_ready, full, empty, count} from the model and current flush input.
  function automatic logic [CW+3:0] exp_status();
    int n = model_q.size();
    return {n != 0, (n < DEPTH) && !flush, n == DEPTH, n == 0, CW'(n)};
  endfunction

  function automatic logic [W-1:0] exp_head();
    return (model_q.size() != 0) ? model_q[0] : '0;
  endfunction

  // Apply inputs, let one rising edge happen, advance the model, and settle 1 time unit.
  task automatic tick(input logic v, input logic [W-1:0] d, input logic r, input logic f);
    bit acc, take;
    in_valid  = v;
    in_packet = d;
    out_ready = r;
    flush     = f;
    acc  = v && (model_q.size() < DEPTH) && !f;
    take = (model_q.size() != 0) && r;
    if (v && !acc && model_stall < SMAX) model_stall++;
    @(posedge clock);
    #1;
    if (f) begin
      model_q.delete();
    end else begin
      if (take) void'(model_q.pop_front());
      if (acc) model_q.push_back(d);
    end
  endtask

  task automatic do_reset();
    clear_n = 1'b0;
    #2;
    model_q.delete();
    model_stall = 0;
    clear_n = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 0; in_packet = '0; out_ready = 0; flush = 0;
    clear_n = 1'b0;
    model_q.delete();
    model_stall = 0;
    #3;
    total++;
    if ({out_valid, in_ready, full, empty, count} !== exp_status()) begin
      bad++; $display("FAIL reset_status got=%b want=%b", {out_valid, in_ready, full, empty, count}, exp_status());
    end
    total++;
    if (out_packet !== '0 || stall_count !== '0) begin
      bad++; $display("FAIL reset_data got pkt=%h stall=%0d want 0/0", out_packet, stall_count);
    end
    clear_n = 1'b1;
  endtask

  task automatic test_single_push();
    tick(1, 24'h123456, 0, 0);
    in_valid = 0;
    #1;
    total++;
    if (out_packet !== 24'h123456 || !out_valid || count !== CW'(1) || empty) begin
      bad++; $display("FAIL single_push got pkt=%h v=%b cnt=%0d e=%b want 123456/1/1/0", out_packet, out_valid, count, empty);
    end
    tick(0, '0, 1, 0);
    total++;
    if ({out_valid, in_ready, full, empty, count} !== exp_status() || out_packet !== '0) begin
      bad++; $display("FAIL single_drain got=%b pkt=%h want=%b pkt=0", {out_valid, in_ready, full, empty, count}, out_packet, exp_status());
    end
  endtask

  task automatic test_fill_stall_drain();
    int base = model_stall;
    for (int i = 1; i <= 4; i++) tick(1, 24'hA00000 + W'(i), 0, 0);
    total++;
    if (!full || in_ready || count !== CW'(4)) begin
      bad++; $display("FAIL fill got full=%b rdy=%b cnt=%0d want 1/0/4", full, in_ready, count);
    end
    for (int i = 0; i < 3; i++) tick(1, 24'hBBBBBB, 0, 0);
    total++;
    if (int'(stall_count) !== base + 3 || int'(stall_count) !== model_stall) begin
      bad++; $display("FAIL stall3 got=%0d want=%0d", stall_count, base + 3);
    end
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (out_packet !== 24'hA00000 + W'(i) || out_packet !== exp_head()) begin
        bad++; $display("FAIL drain_order[%0d] got=%h want=%h", i, out_packet, 24'hA00000 + W'(i));
      end
      tick(0, '0, 1, 0);
    end
    total++;
    if (!empty || out_packet !== '0) begin
      bad++; $display("FAIL drain_empty got e=%b pkt=%h want 1/0", empty, out_packet);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 10; k++) begin
      tick(1, W'(k), 1, 0);
      total++;
      if (count !== CW'(1) || out_packet !== W'(k) || out_packet !== exp_head()) begin
        bad++; $display("FAIL stream[%0d] got cnt=%0d pkt=%h want 1/%h", k, count, out_packet, W'(k));
      end
    end
    tick(0, '0, 1, 0);
    total++;
    if (!empty) begin
      bad++; $display("FAIL stream_end got e=%b want 1", empty);
    end
  endtask

  task automatic test_full_pop_push();
    for (int i = 0; i < 4; i++) tick(1, 24'hC00000 + W'(i), 0, 0);
    tick(1, 24'hC00004, 1, 0);
    total++;
    if (count !== CW'(3) || out_packet !== 24'hC00001) begin
      bad++; $display("FAIL full_simul got cnt=%0d pkt=%h want 3/c00001", count, out_packet);
    end
    tick(1, 24'hC00005, 0, 0);
    total++;
    if (count !== CW'(4) || {out_valid, in_ready, full, empty, count} !== exp_status()) begin
      bad++; $display("FAIL full_next got cnt=%0d want 4", count);
    end
    tick(0, '0, 1, 0);
  endtask

  task automatic test_flush();
    int base = model_stall;
    total++;
    if (count !== CW'(3)) begin
      bad++; $display("FAIL flush_pre got cnt=%0d want 3", count);
    end
    tick(1, 24'hDEAD00, 1, 1);
    flush = 0; in_valid = 0;
    #1;
    total++;
    if (count !== '0 || !empty || out_packet !== '0) begin
      bad++; $display("FAIL flush got cnt=%0d e=%b pkt=%h want 0/1/0", count, empty, out_packet);
    end
    total++;
    if (int'(stall_count) !== base + 1) begin
      bad++; $display("FAIL flush_stall got=%0d want=%0d", stall_count, base + 1);
    end
  endtask

  task automatic test_async_reset();
    tick(1, 24'h111111, 0, 0);
    tick(1, 24'h222222, 0, 0);
    in_valid = 0;
    #2;
    clear_n = 1'b0;
    model_q.delete();
    model_stall = 0;
    #1;
    total++;
    if ({out_valid, in_ready, full, empty, count} !== exp_status() || out_packet !== '0 || stall_count !== '0) begin
      bad++; $display("FAIL async_reset got=%b pkt=%h stall=%0d", {out_valid, in_ready, full, empty, count}, out_packet, stall_count);
    end
    #1;
    clear_n = 1'b1;
    tick(1, 24'h333333, 0, 0);
    total++;
    if (count !== CW'(1) || out_packet !== 24'h333333) begin
      bad++; $display("FAIL post_reset got cnt=%0d pkt=%h want 1/333333", count, out_packet);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 3; i++) tick(1, W'(i), 0, 0);
    for (int i = 0; i < 270; i++) tick(1, 24'hEEEEEE, 0, 0);
    total++;
    if (int'(stall_count) !== SMAX || int'(stall_count) !== model_stall) begin
      bad++; $display("FAIL stall_sat got=%0d want=%0d", stall_count, SMAX);
    end
    do_reset();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
      total++;
      if ({out_valid, in_ready, full, empty, count} !== exp_status() || out_packet !== exp_head()
          || int'(stall_count) !== model_stall) begin
        bad++;
        $display("FAIL random[%0d] got st=%b pkt=%h stall=%0d want st=%b pkt=%h stall=%0d", i,
                 {out_valid, in_ready, full, empty, count}, out_packet, stall_count,
                 exp_status(), exp_head(), model_stall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_fill_stall_drain();
    test_back_to_back();
    test_full_pop_push();
    test_flush();
    test_async_reset();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
